// File: rtl/encoder_8to3_queue_if.sv
// Handshake and status bundle for encoder_8to3_queue.
// The master side is the encoder; the slave side is the event source/consumer.
interface encoder_8to3_queue_if;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       overflow;
    logic [7:0] drop_count;

    modport master (
        input  req, ready,
        output code, valid, pending, overflow, drop_count
    );

    modport slave (
        output req, ready,
        input  code, valid, pending, overflow, drop_count
    );
endinterface

// File: rtl/encoder_8to3_queue.sv
// Captures 8 request lines into a pending bitmap and emits them one at a time
// as 3-bit indices over valid/ready, in fixed priority order.
module encoder_8to3_queue #(
    parameter bit EDGE_MODE = 1'b1,
    parameter bit LOW_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    encoder_8to3_queue_if.master bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_next;
    logic [7:0] req_q, pend_q, new_evt, sel_mask, clr, drop_hit;
    logic [7:0] drop_q;
    logic [2:0] sel, code_q;
    logic       load, ovf_q;

    assign new_evt = EDGE_MODE ? (bus.req & ~req_q) : bus.req;

    always_comb begin
        sel = '0;
        if (LOW_FIRST) begin
            for (int unsigned i = 0; i < 8; i++)
                if (pend_q[7 - i]) sel = 3'(7 - i);
        end else begin
            for (int unsigned i = 0; i < 8; i++)
                if (pend_q[i]) sel = 3'(i);
        end
    end

    assign sel_mask = 8'b1 << sel;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_q) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    if (|pend_q) load = 1'b1;
                    else         state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Set wins over clear: a new event on the bit being loaded stays pending.
    assign clr      = load ? sel_mask : '0;
    assign drop_hit = new_evt & pend_q & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            pend_q <= '0;
            code_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            req_q  <= bus.req;
            pend_q <= (pend_q & ~clr) | new_evt;
            if (load) code_q <= sel;
            ovf_q  <= |drop_hit;
            if ((|drop_hit) && (drop_q != '1)) drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.code       = code_q;
    assign bus.valid      = (state == HOLD);
    assign bus.pending    = pend_q;
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_q;
endmodule

// File: doc/encoder_8to3_queue.md
Name: encoder_8to3_queue

Overview:
- Inverse of the team's 3-to-8 decoder: accepts 8 independent request lines and returns each event as a 3-bit binary index.
- Each request event is captured into a pending register.
- Pending events are emitted one at a time as a 3-bit code over a valid/ready handshake, serviced in fixed priority order.
- Sits between raw event sources (buttons, interrupt lines, decoded strobes) and a consumer that needs a binary index.

Parameters:
- EDGE_MODE, 1, 1 = capture on rising edge of req bit; 0 = capture whenever req bit is high (level).
- LOW_FIRST, 1, 1 = lowest pending index has priority; 0 = highest pending index has priority.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request lines, bit i encodes as code i
- code  output  3  binary index of the presented event
- valid  output  1  code holds a valid event
- ready  input  1  consumer accepts code when valid & ready at a rising edge
- pending  output  8  registered pending-event bitmap, excluding the presented event
- overflow  output  1  one-cycle pulse: a new event hit an already-pending bit and was dropped
- drop_count  output  8  saturating count of dropped events

Behaviour:
- Reset, async on rst_n low: code=0, valid=0, pending=0, overflow=0, drop_count=0, req_q=0, state=IDLE.
- In EDGE_MODE, a req bit held high through reset release produces one event on the first clock edge after release.
- new_evt:
  - EDGE_MODE=1: new_evt = req & ~req_q, where req_q is req registered every cycle.
  - EDGE_MODE=0: new_evt = req.
- sel = priority pick of pending per LOW_FIRST; sel_mask = one-hot of sel. sel is combinational from registered pending only.
- States are IDLE and HOLD.
- IDLE, pending != 0:
  - Load code = sel, set valid = 1, go to HOLD.
  - Clear the sel bit in pending.
- IDLE, pending == 0: stay in IDLE, valid = 0.
- HOLD: valid and code stay stable until accepted (valid & ready).
- HOLD, accept with pending != 0: load the next sel and keep valid = 1 (back-to-back, no bubble).
- HOLD, accept with pending == 0: valid = 0, go to IDLE.
- Pending update each edge: pending_next = (pending & ~clr) | new_evt.
  - clr = sel_mask when a load occurs that cycle, else 0.
  - Set wins over clear on the same bit: an event arriving on the bit being loaded stays pending and is emitted again later; no overflow.
- Overflow condition: new_evt[i] & pending[i] & ~clr[i].
  - Drives overflow = 1 for exactly one cycle.
  - Increments drop_count by 1 per cycle, not per bit; drop_count saturates at 255.
  - In level mode, a held req on a pending bit overflows every cycle by design.
- Event on the presented (HOLD) bit: the bit is not in pending, so it is captured normally and re-emitted after acceptance.
- Latency: an event sampled at edge k sets pending after k. If IDLE, valid=1 after edge k+1. Minimum req-to-valid is 2 clocks.
- Throughput: one code per cycle while ready=1 and pending is non-empty.
- ready while valid=0 is ignored.
- The code value is a pure 3-bit binary index; no arithmetic beyond the saturating counter.

Test Plan:
1. Reset with req=8'h00, then pulse req=8'b0010_0000 for 1 cycle, ready=1 → valid high 2 cycles after the pulse edge with code=5 for 1 cycle, then valid=0, pending=0.
2. LOW_FIRST=1, req=8'b1001_0010 in one cycle, ready=1 → codes 1, 4, 7 on consecutive cycles, no gaps. Repeat with LOW_FIRST=0 → codes 7, 4, 1.
3. Backpressure: ready=0, event on bit 3 → code=3 and valid held stable 10 cycles. Raise ready → accepted in 1 cycle, valid drops.
4. Overflow: ready=0, with bit 2 presented and bit 6 pending, pulse req[6] again → overflow=1 for one cycle, drop_count=1, pending[6] still 1. 256+ further drops → drop_count=255.
5. Set-wins: event on bit 0 arrives the same cycle bit 0 is loaded from pending → code=0 presented, pending[0]=1 afterwards, overflow=0, code 0 emitted twice total.
6. Async reset mid-HOLD with pending=8'hF0, rst_n low between edges → outputs clear immediately without a clock. req held at 8'h01 through release (EDGE_MODE=1) → exactly one code=0 event.
